// File: rtl/ysyx_22041211_ifu.sv
// rtl/ysyx_22041211_ifu.sv - instruction fetch unit, one outstanding AXI4-Lite-style read
//
// Takes a fetch PC from the PC counter, issues a single AR/R read to
// instruction memory and hands {inst, pc, fault} to the decoder over a
// valid/ready handshake. Branch redirects (flush_i) discard the fetch in
// progress; misaligned PCs fault without touching memory.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   pc_i/pc_valid_i/pc_ready_o    fetch PC from the PC counter
//   flush_i                       branch redirect, kills the fetch in flight
//   araddr_o/arvalid_o/arready_i  read address channel
//   rdata_i/rresp_i/rvalid_i/rready_o  read data channel
//   inst_o/inst_pc_o/inst_fault_o/inst_valid_o/inst_ready_i  decoder side
//   fetch_cnt_o                   number of instructions delivered
module ysyx_22041211_ifu #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                pc_valid_i,
    output logic                pc_ready_o,
    input  logic                flush_i,
    output logic [ADDR_LEN-1:0] araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic [DATA_LEN-1:0] inst_o,
    output logic [ADDR_LEN-1:0] inst_pc_o,
    output logic                inst_fault_o,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [31:0]         fetch_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_OUT,
        S_DROP
    } state_t;

    state_t state;
    // A flush seen while the address is still waiting for arready; the
    // address cannot be withdrawn, so the matching response is dropped later.
    logic   flush_pending;

    // The reset state is IDLE, so pc_ready is also gated by rst to keep the
    // PC counter from handing over a PC while the unit is held in reset.
    assign pc_ready_o   = (state == S_IDLE) && !rst;
    assign arvalid_o    = (state == S_AR);
    assign rready_o     = (state == S_R) || (state == S_DROP);
    assign inst_valid_o = (state == S_OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            flush_pending <= 1'b0;
            araddr_o      <= '0;
            inst_o        <= '0;
            inst_pc_o     <= '0;
            inst_fault_o  <= 1'b0;
            fetch_cnt_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A flush in this cycle is older than the PC being taken,
                    // so the PC is already the redirected one.
                    if (pc_valid_i) begin
                        araddr_o      <= pc_i;
                        inst_pc_o     <= pc_i;
                        flush_pending <= 1'b0;
                        if (pc_i[1:0] != 2'b00) begin
                            inst_o       <= '0;
                            inst_fault_o <= 1'b1;
                            state        <= S_OUT;
                        end else begin
                            state <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready_i) begin
                        // A flush on the handshake cycle itself also kills the fetch.
                        state         <= (flush_pending || flush_i) ? S_DROP : S_R;
                        flush_pending <= 1'b0;
                    end else if (flush_i) begin
                        flush_pending <= 1'b1;
                    end
                end
                S_R: begin
                    if (flush_i) begin
                        state <= rvalid_i ? S_IDLE : S_DROP;
                    end else if (rvalid_i) begin
                        inst_o       <= rdata_i;
                        inst_fault_o <= (rresp_i != 2'b00);
                        state        <= S_OUT;
                    end
                end
                S_DROP: begin
                    if (rvalid_i) begin
                        state <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else if (inst_ready_i) begin
                        fetch_cnt_o <= fetch_cnt_o + 32'd1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// tb/tb_ysyx_22041211_ifu.sv - randomized self-checking bench for ysyx_22041211_ifu
module tb_ysyx_22041211_ifu;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk          = 1'b0;
    logic          rst          = 1'b0;
    logic [AW-1:0] pc_i         = '0;
    logic          pc_valid_i   = 1'b0;
    logic          pc_ready_o;
    logic          flush_i      = 1'b0;
    logic [AW-1:0] araddr_o;
    logic          arvalid_o;
    logic          arready_i    = 1'b0;
    logic [DW-1:0] rdata_i      = '0;
    logic [1:0]    rresp_i      = '0;
    logic          rvalid_i     = 1'b0;
    logic          rready_o;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_pc_o;
    logic          inst_fault_o;
    logic          inst_valid_o;
    logic          inst_ready_i = 1'b0;
    logic [31:0]   fetch_cnt_o;

    always #5 clk = ~clk;

    ysyx_22041211_ifu #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_fault_o (inst_fault_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h0000_0413;
    endfunction

    // stimulus knobs
    int          k_pc, k_mis, k_flush, k_ar, k_ir, k_arw, k_irw, k_dly, k_lat;
    bit          k_gap, k_fix, k_fl_ar, k_fl_r, k_fl_out;
    logic [31:0] fix_pc, fix_data;
    logic [1:0]  fix_resp;

    // transaction-level reference: the fetch in flight and the memory
    bit          fetch_active = 0, fetch_flushed = 0, f_mis = 0, f_ar_done = 0;
    logic [31:0] f_pc = '0, f_inst = '0;
    logic        f_fault = 1'b0;
    bit          mem_busy = 0;
    int          mem_delay = 0;
    logic [31:0] mem_data_q = '0;
    logic [1:0]  mem_resp_q = '0;
    logic [31:0] exp_cnt = '0;
    bit          exp_idle = 0, seen_valid = 0, last_mis = 0;
    int          cyc = 0, acc_cyc = 0, last_acc = -1, ar_run = 0, ir_run = 0;
    bit          prev_ar_stall = 0, prev_out_stall = 0;
    logic [31:0] prev_araddr = '0;
    logic [63:0] prev_out = '0;
    logic        prev_fault = 1'b0;

    task automatic defaults();
        k_pc = 0; k_mis = 0; k_flush = 0; k_ar = 100; k_ir = 100;
        k_arw = -1; k_irw = -1; k_dly = 0; k_lat = 0;
        k_gap = 0; k_fix = 0; k_fl_ar = 0; k_fl_r = 0; k_fl_out = 0;
        last_acc = -1;
    endtask

    // One clock: check outputs at negedge, pick inputs, then advance the
    // reference across the coming rising edge.
    task automatic step();
        bit accept;
        @(negedge clk);
        cyc++;
        if (prev_ar_stall) begin
            check("ar_held", 64'(arvalid_o), 64'd1);
            check("araddr_stable", 64'(araddr_o), 64'(prev_araddr));
        end
        if (prev_out_stall) begin
            check("out_stable", 64'({inst_pc_o, inst_o}), prev_out);
            check("out_valid_fault_stable", 64'({inst_valid_o, inst_fault_o}), 64'({1'b1, prev_fault}));
        end
        check("fetch_cnt", 64'(fetch_cnt_o), 64'(exp_cnt));
        if (exp_idle) check("idle_after_end", 64'(pc_ready_o), 64'd1);
        exp_idle = 0;
        if (pc_ready_o) check("idle_clean", 64'({fetch_active & ~fetch_flushed, mem_busy}), 64'd0);
        if (arvalid_o) check("ar_legal", 64'({fetch_active, f_mis, f_ar_done}), 64'b100);
        if (inst_valid_o) begin
            check("valid_live", 64'({fetch_active, fetch_flushed}), 64'b10);
            if (k_lat > 0 && !seen_valid) check("latency", 64'(cyc - acc_cyc), 64'(k_lat));
            seen_valid = 1;
        end
        ar_run = arvalid_o ? ar_run + 1 : 0;
        ir_run = inst_valid_o ? ir_run + 1 : 0;

        pc_valid_i = pct(k_pc);
        if (k_fix) begin
            pc_i = fix_pc;
        end else begin
            pc_i = $urandom;
            pc_i[1:0] = pct(k_mis) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        flush_i = pct(k_flush) || (k_fl_ar && arvalid_o && ar_run == 1)
                  || (k_fl_r && rready_o && !fetch_flushed) || (k_fl_out && inst_valid_o);
        arready_i    = (k_arw >= 0) ? (ar_run > k_arw) : pct(k_ar);
        inst_ready_i = (k_irw >= 0) ? (ir_run > k_irw) : pct(k_ir);
        if (mem_busy && mem_delay == 0) begin
            rvalid_i = 1'b1; rdata_i = mem_data_q; rresp_i = mem_resp_q;
        end else begin
            rvalid_i = 1'b0; rdata_i = $urandom; rresp_i = 2'($urandom);
        end

        accept = pc_valid_i && pc_ready_o;
        if (inst_valid_o && inst_ready_i && !flush_i) begin
            check("inst", 64'(inst_o), 64'(f_inst));
            check("inst_pc", 64'(inst_pc_o), 64'(f_pc));
            check("inst_fault", 64'(inst_fault_o), 64'(f_fault));
            exp_cnt++;
            fetch_active = 0;
            exp_idle = 1;
        end
        if (inst_valid_o && flush_i) exp_idle = 1;
        if (rvalid_i && rready_o) begin
            mem_busy = 0;
            if (fetch_flushed || flush_i) exp_idle = 1;
        end else if (mem_busy && mem_delay > 0) begin
            mem_delay--;
        end
        if (arvalid_o && arready_i) begin
            check("araddr", 64'(araddr_o), 64'(f_pc));
            f_ar_done  = 1;
            mem_busy   = 1;
            mem_delay  = (k_dly >= 0) ? k_dly : int'($urandom_range(0, 3));
            mem_data_q = k_fix ? fix_data : mem_word(f_pc);
            mem_resp_q = k_fix ? fix_resp : (pct(25) ? 2'($urandom_range(1, 3)) : 2'b00);
            f_inst     = mem_data_q;
            f_fault    = (mem_resp_q != 2'b00);
        end
        if (flush_i && fetch_active) fetch_flushed = 1;
        if (accept) begin
            check("no_live_fetch", 64'(fetch_active & ~fetch_flushed), 64'd0);
            if (k_gap && last_acc >= 0) check("accept_gap", 64'(cyc - last_acc), last_mis ? 64'd2 : 64'd4);
            fetch_active  = 1;
            fetch_flushed = 0;
            f_pc          = pc_i;
            f_mis         = (pc_i[1:0] != 2'b00);
            f_ar_done     = 0;
            if (f_mis) begin
                f_inst  = '0;
                f_fault = 1'b1;
            end
            acc_cyc    = cyc;
            last_acc   = cyc;
            last_mis   = f_mis;
            seen_valid = 0;
        end
        prev_ar_stall  = arvalid_o && !arready_i;
        prev_araddr    = araddr_o;
        prev_out_stall = inst_valid_o && !inst_ready_i && !flush_i;
        prev_out       = {inst_pc_o, inst_o};
        prev_fault     = inst_fault_o;
    endtask

    task automatic drain();
        defaults();
        repeat (12) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"}, 64'({pc_ready_o, arvalid_o, rready_o, inst_valid_o}), 64'd0);
        check({tag, "_regs"}, 64'({araddr_o, inst_pc_o}), 64'd0);
        check({tag, "_inst"}, 64'({inst_o, fetch_cnt_o}), 64'd0);
        check({tag, "_fault"}, 64'(inst_fault_o), 64'd0);
    endtask

    initial begin
        bit found;
        defaults();
        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_idle = 1;

        // zero-wait fetch
        defaults();
        k_pc = 100; k_fix = 1; fix_pc = 32'h8000_0000; fix_data = 32'h0000_0413; fix_resp = 2'b00;
        k_lat = 3; k_gap = 1;
        repeat (13) step();
        drain();

        // backpressure on AR, R and decoder
        defaults();
        k_pc = 100; k_fix = 1; fix_pc = 32'h8000_0040; fix_data = 32'h1234_5678; fix_resp = 2'b00;
        k_arw = 3; k_dly = 2; k_irw = 4; k_lat = 8;
        repeat (26) step();
        drain();

        // misaligned PC
        defaults();
        k_pc = 100; k_fix = 1; fix_pc = 32'h8000_0002; k_lat = 1; k_gap = 1;
        repeat (9) step();
        drain();

        // bus error
        defaults();
        k_pc = 100; k_fix = 1; fix_pc = 32'h8000_0100; fix_data = 32'hDEAD_BEEF; fix_resp = 2'b10;
        k_lat = 3; k_gap = 1;
        repeat (9) step();
        drain();

        // flush while the address waits, flush in R, flush in OUT with ready
        defaults();
        k_pc = 100; k_arw = 1; k_dly = 2; k_fl_ar = 1;
        repeat (16) step();
        drain();
        defaults();
        k_pc = 100; k_dly = 2; k_fl_r = 1;
        repeat (16) step();
        drain();
        defaults();
        k_pc = 100; k_fl_out = 1;
        repeat (16) step();
        drain();

        // random traffic
        defaults();
        k_pc = 60; k_mis = 10; k_flush = 8; k_ar = 60; k_ir = 60; k_dly = -1;
        repeat (3000) step();
        drain();

        // async reset while waiting in R
        defaults();
        k_pc = 100; k_dly = 3; k_fix = 1; fix_pc = 32'h8000_0200; fix_data = 32'h0000_0013; fix_resp = 2'b00;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (rready_o) found = 1;
        end
        check("reach_r", 64'(found), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        pc_valid_i = 1'b0; rvalid_i = 1'b0; flush_i = 1'b0; arready_i = 1'b0; inst_ready_i = 1'b0;
        fetch_active = 0; fetch_flushed = 0; mem_busy = 0; exp_cnt = '0;
        prev_ar_stall = 0; prev_out_stall = 0; ar_run = 0; ir_run = 0;
        defaults();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_idle = 1;
        step();

        defaults();
        k_pc = 60; k_mis = 10; k_flush = 8; k_ar = 60; k_ir = 60; k_dly = -1;
        repeat (300) step();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_ifu.md
Name: ysyx_22041211_ifu

Overview:
Instruction fetch unit. Accepts fetch PCs from the PC counter, issues one AXI4-Lite-style read (AR/R channels) to instruction memory, and hands the instruction word plus its PC downstream to the decoder over a valid/ready handshake. It is the consumer side of the PC-counter interface. It also handles branch-redirect flushes and fetch faults. One fetch is outstanding at a time.

Parameters:
ADDR_LEN, 32, width of PC and memory address
DATA_LEN, 32, width of instruction word and read data

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
pc_i  input  ADDR_LEN  fetch address from PC counter
pc_valid_i  input  1  pc_i is valid
pc_ready_o  output  1  IFU accepts pc_i this cycle
flush_i  input  1  branch redirect; discard any fetch older than this cycle
araddr_o  output  ADDR_LEN  read address
arvalid_o  output  1  read address valid
arready_i  input  1  memory accepts address
rdata_i  input  DATA_LEN  read data
rresp_i  input  2  read response; 2'b00 is OKAY, anything else is an error
rvalid_i  input  1  read data valid
rready_o  output  1  IFU accepts read data
inst_o  output  DATA_LEN  fetched instruction
inst_pc_o  output  ADDR_LEN  PC of inst_o
inst_fault_o  output  1  fetch fault (misaligned PC or rresp error)
inst_valid_o  output  1  inst_o, inst_pc_o and inst_fault_o are valid
inst_ready_i  input  1  decoder accepts instruction
fetch_cnt_o  output  32  count of instructions delivered (inst_valid_o & inst_ready_i)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All registered outputs clear to 0: araddr_o, inst_o, inst_pc_o, inst_fault_o, fetch_cnt_o.
  - While rst=1: arvalid_o=0, rready_o=0, inst_valid_o=0, pc_ready_o=0.
- FSM states: IDLE, AR, R, OUT, DROP. All handshake outputs are decoded from state.
  - pc_ready_o = (state==IDLE)
  - arvalid_o = (state==AR)
  - rready_o = (state==R or state==DROP)
  - inst_valid_o = (state==OUT)
- IDLE:
  - On pc_valid_i & pc_ready_o, latch pc_i into inst_pc_o and araddr_o.
  - If pc_i[1:0]!=0: inst_o=0, inst_fault_o=1, go to OUT. No memory access is made.
  - Otherwise go to AR.
  - flush_i in IDLE has no effect; a pc accepted in the same cycle is treated as the post-redirect PC.
- AR:
  - arvalid_o stays high and araddr_o stays stable until arready_i. arvalid_o is never withdrawn early.
  - On handshake, go to R, or to DROP if a flush was pending.
  - flush_i in AR sets a flush_pending flag. The flag clears on leaving AR.
- R:
  - On rvalid_i: latch rdata_i into inst_o, set inst_fault_o = (rresp_i!=0), go to OUT.
  - flush_i in R with rvalid_i in the same cycle: discard the data, go to IDLE.
  - flush_i in R without rvalid_i: go to DROP.
- DROP:
  - rready_o=1. On rvalid_i, discard the data and go to IDLE.
  - Further flush_i pulses are ignored.
- OUT:
  - Outputs are held stable while inst_ready_i=0.
  - On inst_ready_i: fetch_cnt_o increments by 1 (wraps at 2^32), go to IDLE.
  - flush_i in OUT: go to IDLE without delivering and without counting. flush_i takes priority over inst_ready_i in the same cycle.
- Latency with zero-wait memory and ready decoder:
  - PC accepted in cycle N
  - arvalid_o high in N+1 (arready_i=1)
  - rready_o high in N+2 (rvalid_i=1)
  - inst_valid_o high in N+3
  - Next pc_ready_o in N+4
- No ROM/pipelining: exactly one AR transaction is outstanding, and R data is never accepted outside R or DROP.
- Reset mid-transaction returns the FSM to IDLE immediately. Any memory response still in flight is the memory's responsibility; the memory is reset from the same rst.

Test Plan:
- Zero-wait fetch: pc_i=0x80000000, memory returns rdata=0x00000413 with rresp=0 -> inst_valid_o in cycle N+3, inst_o=0x00000413, inst_pc_o=0x80000000, inst_fault_o=0, fetch_cnt_o=1 after the handshake.
- Backpressure: arready_i delayed 3 cycles, rvalid_i delayed 2 cycles, inst_ready_i low for 4 cycles -> araddr_o and inst_o stay stable throughout, exactly one AR handshake, inst_valid_o at N+8, fetch_cnt_o increments once.
- Misaligned PC: pc_i=0x80000002 -> no arvalid_o ever, inst_valid_o at N+1 with inst_fault_o=1, inst_o=0.
- Bus error: rresp_i=2'b10 with rdata=0xDEADBEEF -> inst_fault_o=1, inst_o=0xDEADBEEF delivered.
- Flush in flight: flush_i in AR, then flush_i in R (separate runs), with rvalid_i 2 cycles later -> no inst_valid_o, rready_o consumes the response, pc_ready_o returns high the cycle after rvalid_i, fetch_cnt_o unchanged. Flush in OUT together with inst_ready_i -> no count.
- Async reset in R state: rst asserted mid-cycle -> outputs clear immediately with no clock edge, pc_ready_o=1 in the first cycle after release, fetch_cnt_o=0.
